// File: rtl/proj_index_gen.sv
// ---------------------------------------------------------------------------
// Module      : proj_index_gen
// Description : Strided, multi-pass index generator with valid/ready output.
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package proj_pkg;
   localparam int INDICE_LEN = 8;
endpackage

module proj_index_gen #(
   parameter int INDICE_LEN = proj_pkg::INDICE_LEN,
   parameter int PASS_LEN   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [INDICE_LEN-1:0] cfg_last,
   input  logic [INDICE_LEN-1:0] cfg_stride,
   input  logic [PASS_LEN-1:0]   cfg_passes,
   input  logic                  cfg_wrap,
   input  logic                  out_ready,
   output logic [INDICE_LEN-1:0] out_index,
   output logic [PASS_LEN-1:0]   out_pass,
   output logic                  out_valid,
   output logic                  out_last_pass_beat,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  cfg_err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state;
   logic [INDICE_LEN-1:0] r_index;
   logic [PASS_LEN-1:0]   r_pass;
   logic                  r_start_prev;
   logic                  r_cfg_err;
   logic [INDICE_LEN-1:0] r_last;
   logic [INDICE_LEN-1:0] r_stride;
   logic [PASS_LEN-1:0]   r_passes;
   logic                  r_wrap;

   state_t                w_state_nxt;
   logic [INDICE_LEN-1:0] w_index_nxt;
   logic [PASS_LEN-1:0]   w_pass_nxt;
   logic                  w_cfg_err_nxt;
   logic                  w_latch;
   logic                  w_start_edge;
   logic                  w_run;
   logic                  w_xfer;
   logic                  w_eop;
   logic                  w_final_pass;
   logic [INDICE_LEN:0]   w_sum;

   // One extra bit so the end-of-pass test never sees a wrapped sum.
   assign w_sum        = {1'b0, r_index} + {1'b0, r_stride};
   assign w_eop        = (w_sum > {1'b0, r_last});
   assign w_final_pass = (r_pass == r_passes);
   assign w_run        = (r_state == S_RUN);
   assign w_xfer       = w_run & out_ready;
   assign w_start_edge = start & ~r_start_prev;

   always_comb begin
      w_state_nxt   = r_state;
      w_index_nxt   = r_index;
      w_pass_nxt    = r_pass;
      w_cfg_err_nxt = 1'b0;
      w_latch       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start_edge) begin
               if (cfg_stride != '0) begin
                  w_latch     = 1'b1;
                  w_state_nxt = S_RUN;
                  w_index_nxt = '0;
                  w_pass_nxt  = '0;
               end else begin
                  w_cfg_err_nxt = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               w_state_nxt = S_IDLE;
               w_index_nxt = '0;
               w_pass_nxt  = '0;
            end else if (w_xfer) begin
               if (!w_eop) begin
                  w_index_nxt = w_sum[INDICE_LEN-1:0];
               end else if (!w_final_pass) begin
                  w_index_nxt = '0;
                  w_pass_nxt  = r_pass + PASS_LEN'(1);
               end else begin
                  w_index_nxt = '0;
                  w_pass_nxt  = '0;
                  if (!r_wrap) begin
                     w_state_nxt = S_DONE;
                  end
               end
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_index_nxt = '0;
            w_pass_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_index      <= '0;
         r_pass       <= '0;
         r_start_prev <= 1'b0;
         r_cfg_err    <= 1'b0;
         r_last       <= '0;
         r_stride     <= '0;
         r_passes     <= '0;
         r_wrap       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_index      <= w_index_nxt;
         r_pass       <= w_pass_nxt;
         r_start_prev <= start;
         r_cfg_err    <= w_cfg_err_nxt;
         if (w_latch) begin
            r_last   <= cfg_last;
            r_stride <= cfg_stride;
            r_passes <= cfg_passes;
            r_wrap   <= cfg_wrap;
         end
      end
   end

   assign out_index          = r_index;
   assign out_pass           = r_pass;
   assign out_valid          = w_run;
   assign busy               = w_run;
   assign done               = (r_state == S_DONE);
   assign cfg_err            = r_cfg_err;
   assign out_last_pass_beat = w_run & w_eop;
   assign out_last           = w_run & w_eop & w_final_pass;

endmodule

`default_nettype wire

// File: tb/tb_proj_index_gen.sv
// ---------------------------------------------------------------------------
// Module      : tb_proj_index_gen
// Description : Directed and randomized bench for proj_index_gen against a
//               beat-list reference model.
// Revision    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_proj_index_gen;

   localparam int W = proj_pkg::INDICE_LEN;
   localparam int P = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic [W-1:0] cfg_last = '0;
   logic [W-1:0] cfg_stride = '0;
   logic [P-1:0] cfg_passes = '0;
   logic         cfg_wrap = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_index;
   logic [P-1:0] out_pass;
   logic         out_valid;
   logic         out_last_pass_beat;
   logic         out_last;
   logic         busy;
   logic         done;
   logic         cfg_err;

   always #5 clk = ~clk;

   proj_index_gen #(.INDICE_LEN(W), .PASS_LEN(P)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .cfg_last(cfg_last), .cfg_stride(cfg_stride), .cfg_passes(cfg_passes),
      .cfg_wrap(cfg_wrap), .out_ready(out_ready),
      .out_index(out_index), .out_pass(out_pass), .out_valid(out_valid),
      .out_last_pass_beat(out_last_pass_beat), .out_last(out_last),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a run is the list of beats it must emit, in order.
   typedef struct {
      int p;
      int i;
      bit eop;
      bit lst;
   } beat_t;

   beat_t q[$];
   int    m_mode = 0;           // 0 idle, 1 running, 2 completion pulse
   bit    m_sp = 1'b0;
   bit    m_done = 1'b0;
   bit    m_err = 1'b0;
   bit    m_was_rst = 1'b0;
   int    m_last, m_stride, m_passes;
   bit    m_wrap;

   function void build();
      beat_t b;
      q.delete();
      for (int p = 0; p <= m_passes; p++) begin
         for (int i = 0; i <= m_last; i += m_stride) begin
            b.p   = p;
            b.i   = i;
            b.eop = (i + m_stride > m_last);
            b.lst = b.eop && (p == m_passes);
            q.push_back(b);
         end
      end
   endfunction

   always @(posedge clk) begin
      bit st_edge;
      if (rst) begin
         m_mode = 0; q.delete(); m_sp = 1'b0; m_done = 1'b0; m_err = 1'b0;
         m_was_rst = 1'b1;
      end else begin
         m_was_rst = 1'b0;
         st_edge = start && !m_sp;
         m_sp = start;
         m_done = 1'b0;
         m_err = 1'b0;
         case (m_mode)
            0: if (st_edge) begin
               if (cfg_stride != 0) begin
                  m_last = int'(cfg_last); m_stride = int'(cfg_stride);
                  m_passes = int'(cfg_passes); m_wrap = cfg_wrap;
                  build();
                  m_mode = 1;
               end else begin
                  m_err = 1'b1;
               end
            end
            1: if (abort) begin
               m_mode = 0; q.delete();
            end else if (out_ready) begin
               void'(q.pop_front());
               if (q.size() == 0) begin
                  if (m_wrap) build();
                  else begin m_mode = 2; m_done = 1'b1; end
               end
            end
            default: m_mode = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("valid", out_valid, (m_mode == 1));
         chk("busy", busy, (m_mode == 1));
         chk("done", done, m_done);
         chk("cfg_err", cfg_err, m_err);
         if (m_mode == 1 && q.size() > 0) begin
            chk("index", out_index, q[0].i);
            chk("pass", out_pass, q[0].p);
            chk("last_pass_beat", out_last_pass_beat, q[0].eop);
            chk("last", out_last, q[0].lst);
         end else begin
            chk("last_pass_beat_idle", out_last_pass_beat, 0);
            chk("last_idle", out_last, 0);
         end
         if (m_was_rst) begin
            chk("rst_index", out_index, 0);
            chk("rst_pass", out_pass, 0);
         end
      end
   end

   task automatic cfg(input int l, input int s, input int p, input bit w);
      cfg_last = W'(l); cfg_stride = W'(s); cfg_passes = P'(p); cfg_wrap = w;
   endtask

   int e_i[8] = '{0, 3, 6, 9, 0, 3, 6, 9};
   int e_p[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
   int g_i[8], g_p[8], g_e[8], g_l[8];

   initial begin
      int n, runs;
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("t0_valid", out_valid, 0);
      chk("t0_index", out_index, 0);

      // Single pass, stride 1
      rst = 1'b0; cfg(7, 1, 0, 1'b0); out_ready = 1'b1; start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("t1_idx", out_index, k);
         chk("t1_last", out_last, (k == 7));
         @(negedge clk);
      end
      chk("t1_done", done, 1);
      chk("t1_busy", busy, 0);
      @(negedge clk);
      chk("t1_done_once", done, 0);

      // Two passes, stride 3, ready toggling 1,0,0,1
      cfg(9, 3, 1, 1'b0); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      for (int c = 0; c < 60 && n < 8; c++) begin
         out_ready = (c % 4 == 0) || (c % 4 == 3);
         if (out_valid && out_ready) begin
            g_i[n] = int'(out_index); g_p[n] = int'(out_pass);
            g_e[n] = int'(out_last_pass_beat); g_l[n] = int'(out_last);
            n++;
         end
         @(negedge clk);
      end
      chk("t2_count", n, 8);
      for (int k = 0; k < 8; k++) begin
         chk("t2_idx", g_i[k], e_i[k]);
         chk("t2_pass", g_p[k], e_p[k]);
         chk("t2_eop", g_e[k], (k == 3 || k == 7));
         chk("t2_last", g_l[k], (k == 7));
      end
      chk("t2_done", done, 1);
      out_ready = 1'b1;
      @(negedge clk);

      // Continuous mode, abort on the second lap at index 2
      cfg(3, 1, 0, 1'b1); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid) begin
            chk("t3_idx", out_index, n % 4);
            if (n == 6) break;
            n++;
         end
         @(negedge clk);
      end
      chk("t3_reached", n, 6);
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      chk("t3_valid", out_valid, 0);
      chk("t3_busy", busy, 0);
      runs = 0;
      repeat (5) begin
         if (done) runs++;
         @(negedge clk);
      end
      chk("t3_no_done", runs, 0);

      // Zero stride rejection, then a held start
      cfg(3, 0, 0, 1'b0); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("t4_err", cfg_err, 1);
      chk("t4_busy", busy, 0);
      @(negedge clk);
      chk("t4_err_once", cfg_err, 0);
      cfg(3, 1, 0, 1'b0); start = 1'b1;
      runs = 0;
      repeat (20) begin @(negedge clk); if (done) runs++; end
      chk("t4_one_run", runs, 1);
      start = 1'b0;
      @(negedge clk); start = 1'b1;
      runs = 0;
      repeat (10) begin @(negedge clk); if (done) runs++; end
      chk("t4_second_run", runs, 1);
      start = 1'b0;
      @(negedge clk);

      // Reset mid-run, start held through reset
      cfg(7, 1, 0, 1'b0); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid && out_index == 5) break;
         @(negedge clk);
      end
      chk("t5_at5", out_index, 5);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      chk("t5_valid", out_valid, 0);
      chk("t5_index", out_index, 0);
      chk("t5_busy", busy, 0);
      chk("t5_done", done, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("t5_relaunch", out_valid, 1);
      chk("t5_relaunch_idx", out_index, 0);
      start = 1'b0;
      repeat (12) @(negedge clk);

      // Randomized traffic
      repeat (4000) begin
         rst        = ($urandom_range(0, 499) == 0);
         start      = ($urandom_range(0, 5) == 0);
         abort      = ($urandom_range(0, 59) == 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         cfg_last   = W'($urandom_range(0, 12));
         cfg_stride = W'($urandom_range(0, 4));
         cfg_passes = P'($urandom_range(0, 2));
         cfg_wrap   = ($urandom_range(0, 4) == 0);
         @(negedge clk);
      end
      rst = 1'b0; start = 1'b0; abort = 1'b0;
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/proj_index_gen.md
Name: proj_index_gen

Overview:
- Parametrised successor to the projection index counter.
- Generates a strided index sequence over a configurable buffer length, repeated for a configurable number of passes.
- Supports one-shot and continuous (wrap) modes, a valid/ready output handshake and abort.
- Feeds buffer read addressing in the projection datapath; replaces the fixed-length, free-running counter.

Parameters:
- INDICE_LEN, proj_pkg::INDICE_LEN, width of index output and length/stride config.
- PASS_LEN, 4, width of pass counter and pass config.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level; a rising edge (start=1, start_prev=0) launches a run from IDLE.
- abort  input  1  terminates a run; takes effect next cycle.
- cfg_last  input  INDICE_LEN  highest legal index (length-1); sampled on accepted start.
- cfg_stride  input  INDICE_LEN  index increment, must be >=1; sampled on accepted start.
- cfg_passes  input  PASS_LEN  number of passes minus 1; sampled on accepted start.
- cfg_wrap  input  1  1 = continuous, restart after final pass; sampled on accepted start.
- out_ready  input  1  consumer accepts current index.
- out_index  output  INDICE_LEN  current index.
- out_pass  output  PASS_LEN  current pass number.
- out_valid  output  1  out_index/out_pass valid.
- out_last_pass_beat  output  1  current beat is the final index of its pass.
- out_last  output  1  current beat is the final beat of the run (final pass, final index).
- busy  output  1  state is RUN.
- done  output  1  one-cycle pulse on one-shot completion.
- cfg_err  output  1  one-cycle pulse on start rejected due to cfg_stride==0.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; out_index=0, out_pass=0, out_valid=0, out_last_pass_beat=0, out_last=0, busy=0, done=0, cfg_err=0, start_prev=0.
  - Start held high in the first cycle after reset counts as a rising edge.
- Reset mid-run aborts immediately: no done pulse.
- start_prev <= start every non-reset cycle, in all states.
- States: IDLE, RUN, DONE.
- IDLE:
  - Start edge with cfg_stride!=0: latch cfg_*, index=0, pass=0, go RUN next cycle.
  - Start edge with cfg_stride==0: cfg_err=1 for one cycle, stay IDLE.
- Latency: start edge sampled at cycle N -> out_valid=1 and out_index=0 at cycle N+1.
- RUN:
  - out_valid=1, busy=1.
  - Beat transfers when out_valid & out_ready. Without a transfer, out_index/out_pass/flags hold stable.
  - Next-index arithmetic uses INDICE_LEN+1 bits: sum = out_index + stride.
  - End of pass when sum > last_latched. The beat is still emitted; no out-of-range index is ever output.
  - out_last_pass_beat = (out_index + stride > last_latched), combinational from registered state.
  - out_last = out_last_pass_beat & (out_pass == passes_latched).
- On transfer:
  - Not end of pass: out_index <= sum.
  - End of pass, not final pass: out_index <= 0, out_pass <= out_pass+1.
  - Final beat with wrap=0: go DONE; out_valid=0 next cycle.
  - Final beat with wrap=1: out_index <= 0, out_pass <= 0, stay RUN, no done.
- DONE: done=1 for exactly one cycle, then IDLE. out_valid=0, busy=0.
- Start edges in RUN or DONE are ignored and not queued.
- Abort:
  - In RUN: next cycle IDLE, out_valid=0, no done pulse. Overrides any transfer completing in the same cycle.
  - In IDLE/DONE: no effect, except that DONE still pulses.
- Priority: rst > abort > beat transfer > start.
- cfg_last=0: every beat is end-of-pass; sequence is index 0 repeated passes+1 times.
- cfg_stride > cfg_last: one beat (index 0) per pass.
- cfg_* changes outside an accepted start have no effect on a run in progress.

Test Plan:
- cfg_last=7, stride=1, passes=0, wrap=0, ready=1, start pulse -> out_index 0..7 on consecutive cycles; out_last at index 7; done=1 exactly one cycle after the index-7 beat; busy falls with it.
- cfg_last=9, stride=3, passes=1 -> beats (pass,index) = (0,0),(0,3),(0,6),(0,9),(1,0),(1,3),(1,6),(1,9); out_last_pass_beat on both index-9 beats; out_last only on (1,9).
- Same config, out_ready toggled 1,0,0,1,... -> out_index/out_pass hold during ready=0; the same 8-beat sequence is delivered with no skips or repeats.
- cfg_last=3, stride=1, passes=0, wrap=1 -> 0,1,2,3,0,1,...; no done. Assert abort at index 2 -> next cycle out_valid=0, busy=0, done never pulses.
- start edge with stride=0 -> cfg_err one cycle, busy stays 0. start held high for 20 cycles with a valid config -> exactly one run; second run only after start drops and rises again.
- rst asserted mid-run at index 5 -> next cycle all outputs 0, state IDLE. start high in the first post-reset cycle -> run launches.
